relprime_sequencer: RTL

//  Sequential front end for the subtractive GCD/relprime datapath and its combinational control decoder.

---
 rtl/relprime_sequencer.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/relprime_sequencer.sv
// ---------------------------------------------------------------------------
// relprime_sequencer
//
// Sequential front end for a subtractive GCD datapath. For an operand n it
// searches for the smallest m >= 2 with gcd(n, m) == 1 by launching one GCD
// run per candidate m. The datapath registers a0/a1 are fed back so the
// sequencer can drive the datapath control lines. The datapath loads
// a0 = n, a1 = m_o on start_o or gcd_done_o, freezes on relprime_done_o and
// otherwise subtracts the smaller register from the larger one, steered by
// compare_o.
//
// Ports
//   clk              system clock, rising edge
//   rst_n            asynchronous active-low reset
//   go_i             run request, sampled only in IDLE
//   n_i              operand n, checked when go_i is accepted
//   a0_i, a1_i       current datapath register values
//   start_o          LOAD cycle: datapath loads a0 = n, a1 = m_o
//   gcd_done_o       NEXT cycle: datapath reloads a0 = n, a1 = m_o (new m)
//   relprime_done_o  high from a successful DONE until the next accepted go_i
//   compare_o        a0_i > a1_i while running, 0 elsewhere
//   m_o              current candidate m
//   busy_o           high in LOAD / RUN / NEXT
//   done_o           one-cycle pulse at the end of a search
//   err_o            search failed (n < 2 or candidates exhausted); held
//   result_o         coprime m, 0 on error; held
// ---------------------------------------------------------------------------
module relprime_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             go_i,
  input  logic [WIDTH-1:0] n_i,
  input  logic [WIDTH-1:0] a0_i,
  input  logic [WIDTH-1:0] a1_i,
  output logic             start_o,
  output logic             gcd_done_o,
  output logic             relprime_done_o,
  output logic             compare_o,
  output logic [WIDTH-1:0] m_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [WIDTH-1:0] result_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_NEXT,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             err_q, err_d;
  logic             relprime_q, relprime_d;

  // The operand n itself lives in the datapath (a0 is reloaded from it), so
  // the sequencer only needs n_i at acceptance time to reject n < 2.

  // NOTE: state and every held output are flops with a full async reset;
  // non-blocking assignments keep all of them updating from the same
  // pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      m_q        <= '0;
      result_q   <= '0;
      err_q      <= 1'b0;
      relprime_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      result_q   <= result_d;
      err_q      <= err_d;
      relprime_q <= relprime_d;
    end
  end

  // NOTE: every variable gets its hold value first so no path through the
  // case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    result_d   = result_q;
    err_d      = err_q;
    relprime_d = relprime_q;

    unique case (state_q)
      S_IDLE: begin
        if (go_i) begin
          m_d        = WIDTH'(2);
          result_d   = '0;
          err_d      = 1'b0;
          relprime_d = 1'b0;
          if (n_i < WIDTH'(2)) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_LOAD;
          end
        end
      end

      S_LOAD: state_d = S_RUN;

      S_RUN: begin
        // Equal registers mean the GCD is in a0; this is the evaluation cycle.
        if (a0_i == a1_i) begin
          if (a0_i == WIDTH'(1)) begin
            result_d   = m_q;
            relprime_d = 1'b1;
            state_d    = S_DONE;
          end else if (m_q == '1) begin
            // Last representable candidate rejected: report instead of wrapping.
            err_d    = 1'b1;
            result_d = '0;
            state_d  = S_DONE;
          end else begin
            m_d     = m_q + WIDTH'(1);
            state_d = S_NEXT;
          end
        end
      end

      S_NEXT: state_d = S_RUN;

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // start_o (LOAD), gcd_done_o (NEXT) and relprime_done_o (only set from
  // DONE on, cleared on acceptance) can never overlap by construction.
  assign start_o         = (state_q == S_LOAD);
  assign gcd_done_o      = (state_q == S_NEXT);
  assign relprime_done_o = relprime_q;
  assign compare_o       = (state_q == S_RUN) && (a0_i > a1_i);
  assign m_o             = m_q;
  assign busy_o          = (state_q == S_LOAD) || (state_q == S_RUN) ||
                           (state_q == S_NEXT);
  assign done_o          = (state_q == S_DONE);
  assign err_o           = err_q;
  assign result_o        = result_q;

endmodule
